clk_period_meter: RTL and testbench

Measures the half-period of a slow, free-running toggle signal (e.g. a divided clock from the board clock divider) in units of the fast system clock. It is the receiving end of the divided-clock path: the divider turns a count into a toggle rate; this block recovers the count from the toggle rate. It flags whether the measured half-period is within tolerance of an expected value, and whether the input has stopped toggling. It sits next to the divider for self-check and drives the status LEDs and debug display.

---
 rtl/clk_meter_pkg.sv | 24 ++
 rtl/sync_edge_detect.sv | 45 ++++
 rtl/clk_period_meter.sv | 135 +++++++++++++
 tb/tb_clk_period_meter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_meter_pkg
//  Description : Shared definitions for the clock-period meter. Holds the
//                measurement FSM state encoding and the nominal half-period
//                of each board divider channel.
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_meter_pkg;

    // Measurement FSM state encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        STALL = 2'd2
    } meter_state_t;

    // Nominal half-periods, in system clocks, of the divider channels.
    localparam int unsigned c_ch0_expect = 50000001;
    localparam int unsigned c_ch1_expect = 80000001;
    localparam int unsigned c_ch2_expect = 110000001;

endpackage : clk_meter_pkg
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_detect
//  Description : Brings a slow asynchronous input into the clk domain with a
//                two-flop synchronizer and flags every change (rising or
//                falling) with a one-cycle pulse.
//  Ports       : clk     - system clock
//                rst     - synchronous active-high reset
//                i_sig   - asynchronous slow input
//                o_level - synchronized copy of i_sig (2 clk latency)
//                o_edge  - one-cycle pulse, high in the cycle where the
//                          synchronized value differs from its previous value
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_level,
    output logic o_edge
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_sig;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    // Consumers register on this pulse, so the change is acted upon at the
    // third clk edge after the input moves.
    assign o_edge  = r_sync ^ r_prev;

endmodule : sync_edge_detect
`default_nettype wire

// File: rtl/clk_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : clk_period_meter
//  Description : Measures the half-period of a slow toggle input in clk
//                cycles, flags whether it lies within TOL of EXPECT, and
//                flags a stalled input after TIMEOUT cycles without an edge.
//                Parameter constraint: 2 <= TIMEOUT <= 2**N - 1, so the
//                counter reaches the timeout before it could wrap.
//  Ports       : clk         - system clock
//                rst         - synchronous active-high reset
//                sig_in      - slow toggle input, asynchronous to clk
//                level       - synchronized copy of sig_in
//                half_period - last completed measurement (clk cycles)
//                meas_valid  - one-cycle pulse when half_period updates
//                in_range    - |half_period - EXPECT| <= TOL
//                stalled     - no edge seen for TIMEOUT cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int unsigned N       = 28,
    parameter int unsigned EXPECT  = c_ch0_expect,
    parameter int unsigned TOL     = 2,
    parameter int unsigned TIMEOUT = 120000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sig_in,
    output logic         level,
    output logic [N-1:0] half_period,
    output logic         meas_valid,
    output logic         in_range,
    output logic         stalled
);

    // Tolerance arithmetic is carried at N+1 bits so the subtraction
    // can never wrap regardless of which side is larger.
    localparam logic [N:0]   c_expect  = (N+1)'(EXPECT);
    localparam logic [N:0]   c_tol     = (N+1)'(TOL);
    localparam logic [N-1:0] c_timeout = N'(TIMEOUT);

    meter_state_t r_state;
    meter_state_t w_state_nxt;

    logic         w_edge;
    logic [N-1:0] r_cnt;
    logic [N-1:0] w_cnt_inc;
    logic         w_timeout;
    logic         w_take_meas;
    logic [N:0]   w_meas_ext;
    logic [N:0]   w_dev;

    logic [N-1:0] r_half_period;
    logic         r_meas_valid;
    logic         r_in_range;

    sync_edge_detect u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_sig   (sig_in),
        .o_level (level),
        .o_edge  (w_edge)
    );

    // counter+1 is both the measured value (the edge-detect cycle itself
    // completes the interval) and the timeout comparand.
    assign w_cnt_inc   = r_cnt + N'(1);
    assign w_timeout   = (w_cnt_inc == c_timeout);
    assign w_take_meas = (r_state == ARMED) && w_edge;

    assign w_meas_ext  = {1'b0, w_cnt_inc};
    assign w_dev       = (w_meas_ext >= c_expect) ? (w_meas_ext - c_expect)
                                                  : (c_expect - w_meas_ext);

    // Next-state logic. In ARMED the edge test comes first so an edge that
    // lands on the timeout cycle is measured rather than declared a stall.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_edge) w_state_nxt = ARMED;
            end
            ARMED: begin
                if (w_edge)         w_state_nxt = ARMED;
                else if (w_timeout) w_state_nxt = STALL;
            end
            STALL: begin
                if (w_edge) w_state_nxt = ARMED;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The counter only runs while an interval is open in ARMED; every edge
    // and every exit from ARMED restarts it from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_edge || (w_state_nxt != ARMED)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_half_period <= '0;
            r_meas_valid  <= 1'b0;
            r_in_range    <= 1'b0;
        end else begin
            r_meas_valid <= w_take_meas;
            if (w_take_meas) begin
                r_half_period <= w_cnt_inc;
                r_in_range    <= (w_dev <= c_tol);
            end
        end
    end

    assign half_period = r_half_period;
    assign meas_valid  = r_meas_valid;
    assign in_range    = r_in_range;
    assign stalled     = (r_state == STALL);

endmodule : clk_period_meter
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_period_meter
//  Description : Directed self-checking bench for clk_period_meter with
//                N=8, EXPECT=11, TOL=1, TIMEOUT=40.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_period_meter;

    localparam int unsigned c_n = 8;

    logic           clk;
    logic           rst;
    logic           sig_in;
    logic           level;
    logic [c_n-1:0] half_period;
    logic           meas_valid;
    logic           in_range;
    logic           stalled;

    int n_total;
    int n_bad;

    // Every meas_valid cycle is logged as {half_period, in_range}.
    logic [8:0] q_meas[$];

    clk_period_meter #(
        .N       (c_n),
        .EXPECT  (11),
        .TOL     (1),
        .TIMEOUT (40)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (sig_in),
        .level       (level),
        .half_period (half_period),
        .meas_valid  (meas_valid),
        .in_range    (in_range),
        .stalled     (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (meas_valid) q_meas.push_back({half_period, in_range});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: act=%0d req=%0d", tag, act, exp);
        end
    endtask

    task automatic chk_entry(input int idx, input int hp, input int ir);
        logic [8:0] e;
        e = (idx < q_meas.size()) ? q_meas[idx] : 9'h1ff;
        chk($sformatf("hp[%0d]", idx), int'(e[8:1]), hp);
        chk($sformatf("ir[%0d]", idx), int'(e[0]), ir);
    endtask

    // Wait p clk edges, then toggle: successive calls space detect cycles p apart.
    task automatic gap(input int p);
        repeat (p) @(posedge clk);
        #1 sig_in = ~sig_in;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_level"},    int'(level),       0);
        chk({pfx, "_hp"},       int'(half_period), 0);
        chk({pfx, "_mv"},       int'(meas_valid),  0);
        chk({pfx, "_ir"},       int'(in_range),    0);
        chk({pfx, "_stalled"},  int'(stalled),     0);
    endtask

    int exp_hp[8] = '{11, 11, 11, 11, 10, 12, 9, 13};
    int exp_ir[8] = '{ 1,  1,  1,  1,  1,  1, 0,  0};

    initial begin
        n_total = 0;
        n_bad   = 0;
        sig_in  = 1'b0;
        rst     = 1'b1;

        // Reset with the input toggling.
        repeat (3) begin
            @(posedge clk);
            #1 sig_in = ~sig_in;
        end
        @(negedge clk);
        chk_all_zero("rst");
        @(posedge clk);
        #1 sig_in = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_all_zero("post_rst");
        chk("post_rst_nmeas", q_meas.size(), 0);

        // First edge: also checks level latency (changes on 2nd clk edge).
        @(posedge clk);
        #1 sig_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("level_1clk", int'(level), 0);
        @(posedge clk);
        @(negedge clk);
        chk("level_2clk", int'(level), 1);
        gap(9);   // completes an 11-cycle gap from the first edge
        gap(11);
        gap(11);
        gap(11);
        gap(10);
        gap(12);
        gap(9);
        gap(13);

        // Stall: last detect at +3 after the toggle, stalled visible after +43.
        repeat (42) @(posedge clk);
        @(negedge clk);
        chk("stall_pre", int'(stalled), 0);
        chk("steady_nmeas", q_meas.size(), 8);
        for (int i = 0; i < 8; i++) chk_entry(i, exp_hp[i], exp_ir[i]);
        @(posedge clk);
        @(negedge clk);
        chk("stall_on", int'(stalled), 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("stall_hold", int'(stalled), 1);
        chk("stall_nmeas", q_meas.size(), 8);
        chk("stall_hp_kept", int'(half_period), 13);

        // Recovery edge: clears stalled one cycle after detect, no measurement.
        @(posedge clk);
        #1 sig_in = ~sig_in;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("stall_before_det", int'(stalled), 1);
        @(posedge clk);
        @(negedge clk);
        chk("stall_clr", int'(stalled), 0);
        gap(8);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("recover_nmeas", q_meas.size(), 9);
        chk_entry(8, 11, 1);

        // Edge on the timeout cycle: total gap 40 (5 above + 35).
        gap(35);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("coin_nmeas", q_meas.size(), 10);
        chk_entry(9, 40, 0);
        chk("coin_stalled", int'(stalled), 0);

        // Reset five cycles after an edge-detect cycle.
        gap(1);   // gap 6 from the previous edge
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        sig_in = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_all_zero("mid_rst");
        chk("mid_rst_nmeas", q_meas.size(), 11);
        chk_entry(10, 6, 0);
        @(posedge clk);
        #1 sig_in = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_first_edge", q_meas.size(), 11);
        @(posedge clk);
        #1 sig_in = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_second_edge", q_meas.size(), 12);
        chk_entry(11, 11, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_clk_period_meter
`default_nettype wire
